// File: rtl/dispatch_ctrl.sv
// In-order 2-wide dispatch buffer between decode and the RS/ROB.
// Releases the oldest buffered entries when their RS and ROB credits allow.
package dispatch_pkg;
    typedef struct packed {
        logic        is_valid;
        logic [31:0] pc;
        logic [5:0]  Op;
        logic [2:0]  Unit;
        logic [3:0]  Qj;
        logic [3:0]  Qk;
        logic [31:0] Vj;
        logic [31:0] Vk;
        logic [3:0]  dest;
    } decode_result_t;
endpackage

module dispatch_ctrl
    import dispatch_pkg::*;
#(
    parameter  int N_UNITS   = 4,
    parameter  int RS_DEPTH  = 4,
    parameter  int ROB_DEPTH = 16,
    localparam int CW        = $clog2(RS_DEPTH + 1),
    localparam int RW        = $clog2(ROB_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  decode_result_t              dec_in [2],
    output logic                        in_ready,
    input  logic [N_UNITS-1:0][CW-1:0]  rs_free_cnt,
    input  logic [RW-1:0]               rob_free_cnt,
    output logic [1:0]                  issue_valid,
    output decode_result_t              issue_out [2],
    output logic [15:0]                 stall_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    decode_result_t slot_q [2];
    decode_result_t slot_d [2];
    logic [15:0]    stall_q, stall_d;
    logic           occ0, occ1, same_unit, ok0, ok1;

    // Units outside the RS range only need a ROB entry.
    function automatic logic rs_ok(input logic [2:0] u, input int need,
                                   input logic [N_UNITS-1:0][CW-1:0] cnt);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < N_UNITS; i++) begin
            if (int'(u) == i) ok = (int'(cnt[i]) >= need);
        end
        return ok;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    always_ff @(posedge clk) begin
        slot_q[0] <= slot_d[0];
        slot_q[1] <= slot_d[1];
    end

    always_comb begin
        state_d   = state_q;
        slot_d[0] = slot_q[0];
        slot_d[1] = slot_q[1];
        stall_d   = stall_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else if (in_ready) begin
            // Compact valid entries toward slot0, preserving age order.
            if (dec_in[0].is_valid) begin
                slot_d[0] = dec_in[0];
                slot_d[1] = dec_in[1];
                state_d   = dec_in[1].is_valid ? S_TWO : S_ONE;
            end else if (dec_in[1].is_valid) begin
                slot_d[0] = dec_in[1];
                state_d   = S_ONE;
            end else begin
                state_d = S_EMPTY;
            end
        end else if (issue_valid[0]) begin
            slot_d[0] = slot_q[1];
            state_d   = S_ONE;
        end else if (stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_comb begin
        occ0        = (state_q != S_EMPTY);
        occ1        = (state_q == S_TWO);
        same_unit   = (slot_q[1].Unit == slot_q[0].Unit);
        ok0         = occ0 && (int'(rob_free_cnt) >= 1) && rs_ok(slot_q[0].Unit, 1, rs_free_cnt);
        ok1         = ok0 && occ1 && (int'(rob_free_cnt) >= 2)
                      && rs_ok(slot_q[1].Unit, same_unit ? 2 : 1, rs_free_cnt);
        issue_valid = 2'b00;
        in_ready    = 1'b0;
        if (!flush) begin
            issue_valid = {ok1, ok0};
            case (state_q)
                S_EMPTY: in_ready = 1'b1;
                S_ONE:   in_ready = ok0;
                S_TWO:   in_ready = ok1;
                default: in_ready = 1'b0;
            endcase
        end
        issue_out[0] = slot_q[0];
        issue_out[1] = slot_q[1];
        stall_cnt    = stall_q;
    end

endmodule
